// File: rtl/pingpong_rd_ctrl_pkg.sv
// pingpong_rd_ctrl_pkg: shared state type and default block length for the buffer read controller
package pingpong_rd_ctrl_pkg;
  typedef enum logic {IDLE, READ} rd_ctrl_state_t;
  localparam int DEFAULT_BLOCK_LEN = 192;
endpackage

// File: rtl/pingpong_rd_ctrl_mod_counter.sv
// pingpong_rd_ctrl_mod_counter: enabled counter with sync clear, runtime modulus and wrap flag
module pingpong_rd_ctrl_mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clr,
  input  logic         en,
  input  logic [W:0]   mod_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = {1'b0, cnt_q} == mod_i - 1'b1;
  assign cnt_d = clr ? '0 : en ? (wrap_o ? '0 : cnt_q + 1'b1) : cnt_q;
  assign cnt_o = cnt_q;
  // count register; wraps only at the programmed modulus
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pingpong_rd_ctrl.sv
// pingpong_rd_ctrl: round-robin block reader for the N-bank buffer with a valid/ready output stage
module pingpong_rd_ctrl import pingpong_rd_ctrl_pkg::*; #(
  parameter int MAX_LEN   = DEFAULT_BLOCK_LEN,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 sync_clr,
  input  logic [ADDR_W:0]      block_len_i,
  input  logic [NUM_BANKS-1:0] bank_full_i,
  output logic [NUM_BANKS-1:0] bank_rel_o,
  output logic                 rd_en,
  output logic [BANK_W-1:0]    rd_bank,
  output logic [ADDR_W-1:0]    rdaddress,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);
  localparam logic [ADDR_W:0] MAX_L = (ADDR_W+1)'(MAX_LEN);
  localparam logic [BANK_W:0] NB    = (BANK_W+1)'(NUM_BANKS);
  rd_ctrl_state_t state_q, state_d;
  logic [ADDR_W:0] len_q, len_d, len_sel;
  logic [NUM_BANKS-1:0] rel_q, rel_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [ADDR_W-1:0] cnt;
  logic [BANK_W-1:0] bank, next_bank;
  logic cnt_wrap, bank_wrap, adv, issue, last;
  assign adv = !out_valid_q || out_ready;
  assign issue = state_q == READ && adv;
  assign last = issue && cnt_wrap;
  assign next_bank = bank_wrap ? '0 : bank + 1'b1;
  assign len_sel = (block_len_i == '0 || block_len_i > MAX_L) ? MAX_L : block_len_i;
  assign out_valid_d = issue || (out_valid_q && !out_ready);
  assign out_last_d = adv ? last : out_last_q;
  assign rel_d = last ? (NUM_BANKS)'(1) << bank : '0;
  pingpong_rd_ctrl_mod_counter #(.W(ADDR_W)) u_addr (
    .clk(clk), .resetN(resetN), .clr(sync_clr), .en(issue),
    .mod_i(len_q), .cnt_o(cnt), .wrap_o(cnt_wrap)
  );
  pingpong_rd_ctrl_mod_counter #(.W(BANK_W)) u_bank (
    .clk(clk), .resetN(resetN), .clr(sync_clr), .en(last),
    .mod_i(NB), .cnt_o(bank), .wrap_o(bank_wrap)
  );
  // next state and length latch: start on the current bank only, chain straight into the next full bank
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    if (state_q == IDLE) begin
      if (bank_full_i[bank]) begin
        state_d = READ;
        len_d = len_sel;
      end
    end else if (last) begin
      if (bank_full_i[next_bank]) len_d = len_sel;
      else state_d = IDLE;
    end
  end
  // state, length and output-stage registers; sync_clr discards any block in flight
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      len_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      rel_q <= '0;
    end else if (sync_clr) begin
      state_q <= IDLE;
      len_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      rel_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      rel_q <= rel_d;
    end
  assign rd_en = issue;
  assign rdaddress = state_q == READ ? cnt : '0;
  assign rd_bank = bank;
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign bank_rel_o = rel_q;
endmodule

// File: tb/tb_pingpong_rd_ctrl.sv
// tb_pingpong_rd_ctrl: randomized scenario bench for the buffer read controller with a stream-level model
module tb_pingpong_rd_ctrl;
  logic clk = 1'b0;
  logic resetN, sync_clr, out_ready;
  logic [8:0] block_len, block_len3;
  logic [1:0] bank_full, bank_rel;
  logic [2:0] bank_full3, bank_rel3;
  logic rd_en, out_valid, out_last, rd_en3, out_valid3, out_last3;
  logic [0:0] rd_bank;
  logic [1:0] rd_bank3;
  logic [7:0] rdaddress, rdaddress3;
  int n_checks = 0, n_pass = 0;
  int cyc, viol, rdy_mode;
  int ram_bank, ram_addr, ram_bank3, ram_addr3;
  int got[$], got_cyc[$], got3[$], rels[$], rels3[$], exp_q[$];

  always #5 clk = ~clk;

  pingpong_rd_ctrl dut (
    .clk(clk), .resetN(resetN), .sync_clr(sync_clr), .block_len_i(block_len),
    .bank_full_i(bank_full), .bank_rel_o(bank_rel), .rd_en(rd_en), .rd_bank(rd_bank),
    .rdaddress(rdaddress), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );
  pingpong_rd_ctrl #(.NUM_BANKS(3)) dut3 (
    .clk(clk), .resetN(resetN), .sync_clr(sync_clr), .block_len_i(block_len3),
    .bank_full_i(bank_full3), .bank_rel_o(bank_rel3), .rd_en(rd_en3), .rd_bank(rd_bank3),
    .rdaddress(rdaddress3), .out_valid(out_valid3), .out_last(out_last3), .out_ready(out_ready)
  );

  // buffer RAMs with one-cycle read latency; output holds when no read is issued
  always @(posedge clk) begin
    if (rd_en) begin ram_bank <= int'(rd_bank); ram_addr <= int'(rdaddress); end
    if (rd_en3) begin ram_bank3 <= int'(rd_bank3); ram_addr3 <= int'(rdaddress3); end
  end

  function automatic int enc(int b, int a, bit l);
    return (l ? 100000 : 0) + b * 1000 + a;
  endfunction

  function automatic int eff_len(int l);
    return (l == 0 || l > 192) ? 192 : l;
  endfunction

  function automatic void push_block(int b, int len);
    for (int a = 0; a < len; a++) exp_q.push_back(enc(b, a, a == len - 1));
  endfunction

  task automatic step();
    @(negedge clk);
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ((cyc % 4 == 1 || cyc % 4 == 2) ? 1'b0 : 1'b1) : 1'($urandom_range(0, 1));
    #1;
    if (out_valid && out_ready) begin got.push_back(enc(ram_bank, ram_addr, out_last)); got_cyc.push_back(cyc); end
    if (out_valid3 && out_ready) got3.push_back(enc(ram_bank3, ram_addr3, out_last3));
    if (bank_rel != 0) rels.push_back(int'(bank_rel));
    if (bank_rel3 != 0) rels3.push_back(int'(bank_rel3));
    if (rd_en && out_valid && !out_ready) viol++;
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, input bit three);
    int k = 0;
    while ((three ? got3.size() : got.size()) < n && k < budget) begin step(); k++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; sync_clr = 1'b0; bank_full = '0; bank_full3 = '0; out_ready = 1'b1;
    block_len = 9'd192; block_len3 = 9'd192; rdy_mode = 0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    got.delete(); got_cyc.delete(); got3.delete(); rels.delete(); rels3.delete(); exp_q.delete();
    viol = 0; cyc = 0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; sync_clr = 1'b0; bank_full = 2'b01; bank_full3 = 3'b111; out_ready = 1'b0;
    block_len = 9'd192; block_len3 = 9'd192;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b exp 0", rd_en); else n_pass++;
    n_checks++; if (rdaddress !== 8'd0) $display("FAIL reset_rdaddress got %0d exp 0", rdaddress); else n_pass++;
    n_checks++; if (rd_bank !== 1'b0) $display("FAIL reset_rd_bank got %0d exp 0", rd_bank); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else n_pass++;
    n_checks++; if (bank_rel !== 2'b00 || bank_rel3 !== 3'b000) $display("FAIL reset_bank_rel got %b/%b exp 0", bank_rel, bank_rel3); else n_pass++;
  endtask

  task automatic test_single_block();
    int bad = -1;
    do_reset();
    bank_full = 2'b01;
    push_block(0, 192);
    run_until(192, 1000, 0);
    repeat (5) step();
    foreach (exp_q[i]) if (i < got.size() && got[i] !== exp_q[i] && bad < 0) bad = i;
    n_checks++;
    if (got.size() != exp_q.size() || bad >= 0)
      $display("FAIL single_words count %0d exp %0d first bad idx %0d got %0d exp %0d", got.size(), exp_q.size(), bad, bad >= 0 ? got[bad] : 0, bad >= 0 ? exp_q[bad] : 0);
    else n_pass++;
    n_checks++; if (rels.size() != 1 || rels[0] != 1) $display("FAIL single_release count %0d first %0d exp 1 pulse of 01", rels.size(), rels.size() > 0 ? rels[0] : 0); else n_pass++;
    n_checks++; if (rd_en !== 1'b0 || out_valid !== 1'b0) $display("FAIL single_idle rd_en %b out_valid %b exp 0 0", rd_en, out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad = -1;
    do_reset();
    bank_full = 2'b11;
    push_block(0, 192); push_block(1, 192);
    run_until(384, 1000, 0);
    foreach (exp_q[i]) if (i < got.size() && got[i] !== exp_q[i] && bad < 0) bad = i;
    n_checks++;
    if (got.size() != exp_q.size() || bad >= 0)
      $display("FAIL b2b_words count %0d exp %0d first bad idx %0d got %0d exp %0d", got.size(), exp_q.size(), bad, bad >= 0 ? got[bad] : 0, bad >= 0 ? exp_q[bad] : 0);
    else n_pass++;
    n_checks++;
    if (got_cyc.size() < 193 || got_cyc[192] != got_cyc[191] + 1)
      $display("FAIL b2b_bubble gap cycles %0d exp 1", got_cyc.size() < 193 ? -1 : got_cyc[192] - got_cyc[191]);
    else n_pass++;
    n_checks++;
    if (rels.size() < 2 || rels[0] != 1 || rels[1] != 2)
      $display("FAIL b2b_release got %0d,%0d exp 1,2", rels.size() > 0 ? rels[0] : 0, rels.size() > 1 ? rels[1] : 0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = -1;
    do_reset();
    bank_full = 2'b01; rdy_mode = 1;
    push_block(0, 192);
    run_until(192, 2000, 0);
    repeat (8) step();
    foreach (exp_q[i]) if (i < got.size() && got[i] !== exp_q[i] && bad < 0) bad = i;
    n_checks++;
    if (got.size() != exp_q.size() || bad >= 0)
      $display("FAIL bp_words count %0d exp %0d first bad idx %0d got %0d exp %0d", got.size(), exp_q.size(), bad, bad >= 0 ? got[bad] : 0, bad >= 0 ? exp_q[bad] : 0);
    else n_pass++;
    n_checks++; if (viol != 0) $display("FAIL bp_read_while_stalled got %0d cycles exp 0", viol); else n_pass++;
    n_checks++; if (rels.size() != 1 || rels[0] != 1) $display("FAIL bp_release count %0d exp 1", rels.size()); else n_pass++;
  endtask

  task automatic test_block_len();
    int bad = -1, k = 0;
    do_reset();
    bank_full = 2'b11; block_len = 9'd96;
    push_block(0, 96); push_block(1, 192);
    while (!rd_en && k < 20) begin step(); k++; end
    block_len = 9'd0;
    run_until(96 + 192, 1000, 0);
    foreach (exp_q[i]) if (i < got.size() && got[i] !== exp_q[i] && bad < 0) bad = i;
    n_checks++;
    if (got.size() != exp_q.size() || bad >= 0)
      $display("FAIL len_words count %0d exp %0d first bad idx %0d got %0d exp %0d", got.size(), exp_q.size(), bad, bad >= 0 ? got[bad] : 0, bad >= 0 ? exp_q[bad] : 0);
    else n_pass++;
    n_checks++;
    if (rels.size() < 2 || rels[0] != 1 || rels[1] != 2)
      $display("FAIL len_release got %0d,%0d exp 1,2", rels.size() > 0 ? rels[0] : 0, rels.size() > 1 ? rels[1] : 0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      int bad = -1, l, len;
      do_reset();
      l = $urandom_range(0, 300);
      len = eff_len(l);
      block_len = 9'(l); bank_full = 2'b11; rdy_mode = 2;
      for (int b = 0; b < 3; b++) push_block(b % 2, len);
      run_until(3 * len, 3 * len * 10 + 100, 0);
      foreach (exp_q[i]) if (i < got.size() && got[i] !== exp_q[i] && bad < 0) bad = i;
      n_checks++;
      if (got.size() != exp_q.size() || bad >= 0)
        $display("FAIL rand_words len %0d count %0d exp %0d first bad idx %0d got %0d exp %0d", l, got.size(), exp_q.size(), bad, bad >= 0 ? got[bad] : 0, bad >= 0 ? exp_q[bad] : 0);
      else n_pass++;
      n_checks++; if (viol != 0) $display("FAIL rand_read_while_stalled got %0d cycles exp 0", viol); else n_pass++;
      n_checks++;
      if (rels.size() < 3 || rels[0] != 1 || rels[1] != 2 || rels[2] != 1)
        $display("FAIL rand_release count %0d exp 3 pulses 1,2,1", rels.size());
      else n_pass++;
    end
  endtask

  task automatic test_sync_clr();
    int k = 0;
    bit bank1_last = 0;
    do_reset();
    bank_full = 2'b11;
    while (!(rd_en && rd_bank == 1'b1 && rdaddress == 8'd50) && k < 1000) begin step(); k++; end
    n_checks++; if (k >= 1000) $display("FAIL clr_reach_addr50 got timeout exp bank1 addr50"); else n_pass++;
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || rd_en !== 1'b0) $display("FAIL clr_idle out_valid %b rd_en %b exp 0 0", out_valid, rd_en); else n_pass++;
    n_checks++; if (bank_rel !== 2'b00) $display("FAIL clr_no_release got %b exp 00", bank_rel); else n_pass++;
    step();
    n_checks++;
    if (rd_en !== 1'b1 || rd_bank !== 1'b0 || rdaddress !== 8'd0)
      $display("FAIL clr_restart rd_en %b bank %0d addr %0d exp 1 0 0", rd_en, rd_bank, rdaddress);
    else n_pass++;
    repeat (10) step();
    n_checks++; if (rels.size() != 1 || rels[0] != 1) $display("FAIL clr_release_list count %0d exp only 01", rels.size()); else n_pass++;
    foreach (got[i]) if (got[i] >= 100000 && (got[i] % 100000) / 1000 == 1) bank1_last = 1;
    n_checks++; if (bank1_last) $display("FAIL clr_bank1_last got last word on bank1 exp none"); else n_pass++;
  endtask

  task automatic test_three_banks();
    int bad = -1;
    do_reset();
    bank_full3 = 3'b111; block_len3 = 9'd16;
    for (int b = 0; b < 4; b++) push_block(b % 3, 16);
    run_until(64, 500, 1);
    foreach (exp_q[i]) if (i < got3.size() && got3[i] !== exp_q[i] && bad < 0) bad = i;
    n_checks++;
    if (got3.size() != exp_q.size() || bad >= 0)
      $display("FAIL nb3_words count %0d exp %0d first bad idx %0d got %0d exp %0d", got3.size(), exp_q.size(), bad, bad >= 0 ? got3[bad] : 0, bad >= 0 ? exp_q[bad] : 0);
    else n_pass++;
    n_checks++;
    if (rels3.size() < 4 || rels3[0] != 1 || rels3[1] != 2 || rels3[2] != 4 || rels3[3] != 1)
      $display("FAIL nb3_release count %0d exp pulses 1,2,4,1", rels3.size());
    else n_pass++;
  endtask

  initial begin
    rdy_mode = 0; cyc = 0; viol = 0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_block_len();
    test_random();
    test_sync_clr();
    test_three_banks();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
